// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS memory-stage I/O bridge.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam word_t IO_BASE    = 32'hFFFF_0000;
    localparam word_t SW_OFS     = 32'h0000_0000;
    localparam word_t LED_OFS    = 32'h0000_0004;
    localparam word_t COUNT_OFS  = 32'h0000_0008;
    localparam word_t CMP_OFS    = 32'h0000_000C;
    localparam word_t STATUS_OFS = 32'h0000_0010;

    typedef enum logic [2:0] {
        T_RAM,
        T_SW,
        T_LED,
        T_COUNT,
        T_CMP,
        T_STATUS,
        T_NONE
    } target_e;

    // Map a byte address to its target; the two low address bits are ignored.
    function automatic target_e decode_target(input word_t addr, input word_t io_base,
                                              input word_t ram_bytes);
        word_t ofs;
        target_e t;
        ofs = {addr[31:2], 2'b00} - io_base;
        if (addr < ram_bytes) begin
            t = T_RAM;
        end else begin
            case (ofs)
                SW_OFS:     t = T_SW;
                LED_OFS:    t = T_LED;
                COUNT_OFS:  t = T_COUNT;
                CMP_OFS:    t = T_CMP;
                STATUS_OFS: t = T_STATUS;
                default:    t = T_NONE;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// M-stage load/store bus between the pipeline and the memory/I-O bridge.
interface mem_io_bridge_if;
    import mips_pkg::*;

    word_t addr_M;
    word_t wdata_M;
    logic  mem_write_M;
    logic  mem_read_M;
    word_t rdata_W;

    modport master (
        output addr_M, wdata_M, mem_write_M, mem_read_M,
        input  rdata_W
    );

    modport slave (
        input  addr_M, wdata_M, mem_write_M, mem_read_M,
        output rdata_W
    );

endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus whole-vector debounce for the board switches.
module switch_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Restart the stability count on any change; publish the candidate once it has held long enough.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_MAX) begin
                stable_d = cand_q;
            end
        end
    end

    // Synchronizer, candidate, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/mem_io_bridge.sv
// Memory-stage target: data RAM, debounced switch port, LED register and a compare timer.
module mem_io_bridge #(
    parameter int          RAM_WORDS       = 256,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] IO_BASE         = mips_pkg::IO_BASE
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_io_bridge_if.slave   bus,
    input  logic [7:0]       switches,
    output logic [7:0]       leds,
    output logic             timer_irq
);
    import mips_pkg::*;

    localparam int    AW        = $clog2(RAM_WORDS);
    localparam word_t RAM_BYTES = word_t'(RAM_WORDS * 4);

    target_e          tgt;
    logic [AW-1:0]    ram_idx;
    logic             wr_en, rd_en;
    logic [7:0]       sw_stable;

    word_t            ram_q [RAM_WORDS];
    word_t            rdata_q, rdata_d;
    word_t            count_q, count_d;
    word_t            cmp_q, cmp_d;
    logic [7:0]       leds_q, leds_d;
    logic             status_q, status_d;

    assign tgt     = decode_target(bus.addr_M, IO_BASE, RAM_BYTES);
    assign ram_idx = bus.addr_M[AW+1:2];
    assign wr_en   = bus.mem_write_M;
    assign rd_en   = bus.mem_read_M;

    switch_debouncer #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (switches),
        .stable (sw_stable)
    );

    // Data RAM store port; loads read the pre-write contents in the same cycle.
    always_ff @(posedge clk) begin
        if (wr_en && tgt == T_RAM) begin
            ram_q[ram_idx] <= bus.wdata_M;
        end
    end

    // Register updates, timer/match logic and the load-data mux.
    always_comb begin
        leds_d   = leds_q;
        count_d  = count_q + 32'd1;
        cmp_d    = cmp_q;
        status_d = status_q;
        rdata_d  = '0;

        if (wr_en) begin
            case (tgt)
                T_LED:    leds_d  = bus.wdata_M[7:0];
                T_COUNT:  count_d = bus.wdata_M;
                T_CMP:    cmp_d   = bus.wdata_M;
                T_STATUS: if (bus.wdata_M[0]) status_d = 1'b0;
                default:  ;
            endcase
        end

        // A match in the same cycle as a clear keeps the flag set.
        if (count_q == cmp_q) begin
            status_d = 1'b1;
        end

        if (rd_en) begin
            case (tgt)
                T_RAM:    rdata_d = ram_q[ram_idx];
                T_SW:     rdata_d = {24'b0, sw_stable};
                T_LED:    rdata_d = {24'b0, leds_q};
                T_COUNT:  rdata_d = count_q;
                T_CMP:    rdata_d = cmp_q;
                T_STATUS: rdata_d = {31'b0, status_q};
                default:  rdata_d = '0;
            endcase
        end
    end

    // Control and I/O registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            leds_q   <= '0;
            count_q  <= '0;
            cmp_q    <= 32'hFFFF_FFFF;
            status_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            leds_q   <= leds_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
        end
    end

    assign bus.rdata_W = rdata_q;
    assign leds        = leds_q;
    assign timer_irq   = status_q;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: vector table for the bus map, hand sequences for timer, debounce and reset.
module tb_mem_io_bridge;

    localparam logic [31:0] IO     = 32'hFFFF_0000;
    localparam logic [31:0] A_SW   = IO + 32'h00;
    localparam logic [31:0] A_LED  = IO + 32'h04;
    localparam logic [31:0] A_CNT  = IO + 32'h08;
    localparam logic [31:0] A_CMP  = IO + 32'h0C;
    localparam logic [31:0] A_STAT = IO + 32'h10;
    localparam int          NV     = 23;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] switches = 8'h00;
    logic [7:0] leds;
    logic       timer_irq;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [NV];

    mem_io_bridge_if bus();

    mem_io_bridge #(
        .RAM_WORDS       (256),
        .DEBOUNCE_CYCLES (16),
        .IO_BASE         (32'hFFFF_0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .switches  (switches),
        .leds      (leds),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One bus cycle; loads push their expectation and are compared one edge later.
    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic chk, input logic [31:0] exp,
                          input string name);
        logic [31:0] e;
        bus.addr_M      = a;
        bus.wdata_M     = wd;
        bus.mem_write_M = wr;
        bus.mem_read_M  = rd;
        if (rd && chk) exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus.mem_write_M = 1'b0;
        bus.mem_read_M  = 1'b0;
        if (rd) begin
            if (chk) begin
                e = exp_q.pop_front();
                check(name, bus.rdata_W, e);
            end
        end else begin
            check({name, "_rdata_idle"}, bus.rdata_W, 32'h0);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string name);
        access(1'b1, 1'b0, a, d, 1'b0, 32'h0, name);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        access(1'b0, 1'b1, a, 32'h0, 1'b1, exp, name);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.addr_M      = '0;
        bus.wdata_M     = '0;
        bus.mem_write_M = 1'b0;
        bus.mem_read_M  = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0014, 32'h0,         1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,         1'b1, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_03FC, 32'h1122_3344, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0,         1'b1, 32'h1122_3344};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h7777_7777, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0,         1'b1, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
        vecs[12] = '{1'b1, 1'b0, A_LED,         32'h1234_56A5, 1'b0, 32'h0};
        vecs[13] = '{1'b0, 1'b1, A_LED,         32'h0,         1'b1, 32'h0000_00A5};
        vecs[14] = '{1'b1, 1'b0, A_SW,          32'hFFFF_FFFF, 1'b0, 32'h0};
        vecs[15] = '{1'b0, 1'b1, A_LED,         32'h0,         1'b1, 32'h0000_00A5};
        vecs[16] = '{1'b0, 1'b1, A_SW,          32'h0,         1'b1, 32'h0};
        vecs[17] = '{1'b1, 1'b0, IO + 32'h20,   32'h1234_5678, 1'b0, 32'h0};
        vecs[18] = '{1'b0, 1'b1, IO + 32'h20,   32'h0,         1'b1, 32'h0};
        vecs[19] = '{1'b0, 1'b1, A_LED,         32'h0,         1'b1, 32'h0000_00A5};
        vecs[20] = '{1'b1, 1'b1, A_LED,         32'h0000_005A, 1'b1, 32'h0000_00A5};
        vecs[21] = '{1'b0, 1'b1, A_LED,         32'h0,         1'b1, 32'h0000_005A};
        vecs[22] = '{1'b1, 1'b0, A_LED,         32'h0000_00A5, 1'b0, 32'h0};

        // Reset state
        #22;
        check("reset_rdata", bus.rdata_W, 32'h0);
        check("reset_leds", {24'h0, leds}, 32'h0);
        check("reset_irq", {31'h0, timer_irq}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Bus map vectors
        for (int i = 0; i < NV; i++) begin
            access(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                   vecs[i].chk, vecs[i].exp, $sformatf("vec%0d", i));
        end
        check("leds_after_table", {24'h0, leds}, 32'h0000_00A5);

        // Timer match and W1C
        wr(A_CNT, 32'd100, "cnt100");
        wr(A_CMP, 32'd110, "cmp110");
        idle(9);
        rd(A_STAT, 32'h0, "status_before_match");
        check("irq_after_match", {31'h0, timer_irq}, 32'h1);
        rd(A_STAT, 32'h1, "status_match");
        wr(A_STAT, 32'h1, "w1c");
        rd(A_STAT, 32'h0, "status_cleared");
        check("irq_cleared", {31'h0, timer_irq}, 32'h0);

        // COUNT write beats the increment
        wr(A_CNT, 32'd500, "cnt500");
        rd(A_CNT, 32'd500, "cnt_write_wins");
        rd(A_CNT, 32'd501, "cnt_increments");

        // W1C coinciding with a match
        wr(A_CNT, 32'd200, "cnt200");
        wr(A_CMP, 32'd203, "cmp203");
        idle(2);
        wr(A_STAT, 32'h1, "w1c_on_match");
        rd(A_STAT, 32'h1, "status_set_wins");
        wr(A_STAT, 32'h1, "w1c2");
        rd(A_STAT, 32'h0, "status_cleared2");

        // Wrap without a match, then wrap onto CMP=0
        wr(A_CMP, 32'h8000_0000, "cmp_far");
        wr(A_CNT, 32'hFFFF_FFFE, "cnt_fffe");
        rd(A_CNT, 32'hFFFF_FFFE, "wrap0");
        rd(A_CNT, 32'hFFFF_FFFF, "wrap1");
        rd(A_CNT, 32'h0000_0000, "wrap2");
        rd(A_STAT, 32'h0, "wrap_no_flag");
        wr(A_CMP, 32'h0, "cmp0");
        wr(A_CNT, 32'hFFFF_FFFE, "cnt_fffe2");
        idle(3);
        rd(A_STAT, 32'h1, "wrap_match_zero");
        wr(A_STAT, 32'h1, "w1c3");
        wr(A_CMP, 32'hFFFF_FFFF, "cmp_max");

        // Debounce latency and glitch rejection
        switches = 8'h3C;
        idle(17);
        rd(A_SW, 32'h0, "sw_not_early");
        rd(A_SW, 32'h0000_003C, "sw_settled");
        switches = 8'hFF;
        idle(5);
        switches = 8'h3C;
        idle(30);
        rd(A_SW, 32'h0000_003C, "sw_glitch_ignored");

        // Asynchronous reset mid-run with a load in flight
        rd(A_LED, 32'h0000_00A5, "led_before_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_rdata", bus.rdata_W, 32'h0);
        check("midreset_leds", {24'h0, leds}, 32'h0);
        check("midreset_irq", {31'h0, timer_irq}, 32'h0);
        #2;
        rst_n = 1'b1;
        rd(A_CNT, 32'd0, "post_reset_count");
        rd(A_CNT, 32'd1, "post_reset_count_inc");
        rd(A_CMP, 32'hFFFF_FFFF, "post_reset_cmp");
        rd(A_STAT, 32'h0, "post_reset_status");
        rd(A_LED, 32'h0, "post_reset_led");
        rd(A_SW, 32'h0, "post_reset_sw");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
